// File: rtl/ringosc_freq_meter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ringosc_freq_meter_if
//  Purpose  : Control/status bundle of the ring-oscillator frequency meter.
//             master = controller side (drives selects, start, window and the
//             external test source); slave = meter side.
//  Signals  : osc_sel, src_ext, ext_osc, start, continuous, window_cycles
//             (controller -> meter); busy, done, result, overflow
//             (meter -> controller).
//  Revision : 1.0 - initial release
// ============================================================================
interface ringosc_freq_meter_if #(
    parameter int NUM_OSC     = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int WINDOW_BITS = 24
);
    localparam int SEL_W = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;

    logic [SEL_W-1:0]       osc_sel;
    logic                   src_ext;
    logic                   ext_osc;
    logic                   start;
    logic                   continuous;
    logic [WINDOW_BITS-1:0] window_cycles;
    logic                   busy;
    logic                   done;
    logic [CNT_WIDTH-1:0]   result;
    logic                   overflow;

    modport master (
        output osc_sel, src_ext, ext_osc, start, continuous, window_cycles,
        input  busy, done, result, overflow
    );

    modport slave (
        input  osc_sel, src_ext, ext_osc, start, continuous, window_cycles,
        output busy, done, result, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ringosc_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : ringosc_freq_meter
//  Purpose  : Multi-channel ring-oscillator frequency meter. The selected ring
//             (or the external test source) is divided by a ripple prescaler,
//             synchronised into clk and its rising edges are counted over a
//             programmable window of clk cycles. Single-shot or continuous.
//  Ports    : clk  - system clock (rising edge)
//             rst  - synchronous active-high reset
//             bus  - ringosc_freq_meter_if.slave (selects, start, window,
//                    busy/done/result/overflow)
//  Revision : 1.0 - initial release
// ============================================================================
module ringosc_freq_meter #(
    parameter int NUM_OSC       = 4,
    parameter int OSC_LEN       = 13,
    parameter int PRESCALE_BITS = 8,
    parameter int CNT_WIDTH     = 32,
    parameter int WINDOW_BITS   = 24
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ringosc_freq_meter_if.slave    bus
);
    localparam int SEL_W = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_settle  = 2'd1;
    localparam logic [1:0] c_measure = 2'd2;
    localparam logic [1:0] c_done    = 2'd3;

    localparam logic [1:0]             c_settle_last = 2'd3;
    localparam logic [CNT_WIDTH-1:0]   c_cnt_max     = {CNT_WIDTH{1'b1}};
    localparam logic [WINDOW_BITS-1:0] c_win_one     = WINDOW_BITS'(1);

    logic [1:0]             r_state;
    logic [1:0]             r_settle;
    logic [SEL_W-1:0]       r_osc_sel;
    logic                   r_src_ext;
    logic [WINDOW_BITS-1:0] r_win;
    logic [CNT_WIDTH-1:0]   r_edge;
    logic                   r_sat;
    logic [CNT_WIDTH-1:0]   r_result;
    logic                   r_overflow;
    logic                   r_done;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_sync3;

    logic [NUM_OSC-1:0]     w_ring_out;
    logic                   w_src;
    logic                   w_pre_out;
    logic                   w_pre_clr;
    logic                   w_inc;
    logic [WINDOW_BITS-1:0] w_win_load;

    // ------------------------------------------------------------------
    // Ring oscillators. Stage 0 is an AND-inverter: forced low unless this
    // ring is the active measurement source, so idle rings never toggle.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_OSC; k++) begin : g_osc
        localparam int L = OSC_LEN + 2 * k;
        logic [L-1:0] w_stage;
        logic         w_en;

        assign w_en       = (r_state != c_idle) && !r_src_ext && (r_osc_sel == SEL_W'(k));
        assign w_stage[0] = w_en & ~w_stage[L-1];
        for (genvar i = 1; i < L; i++) begin : g_stage
            assign w_stage[i] = ~w_stage[i-1];
        end
        assign w_ring_out[k] = w_stage[L-1];
    end

    assign w_src = r_src_ext ? bus.ext_osc : w_ring_out[r_osc_sel];

    // ------------------------------------------------------------------
    // Ripple prescaler. It runs on the measured source, not on clk, so its
    // clear is necessarily asynchronous; it is derived from the registered
    // state and therefore glitch-free.
    // ------------------------------------------------------------------
    assign w_pre_clr = (r_state == c_idle);

    if (PRESCALE_BITS == 0) begin : g_no_prescale
        assign w_pre_out = w_src;
    end else begin : g_prescale
        for (genvar i = 0; i < PRESCALE_BITS; i++) begin : g_pre_stage
            logic r_q;
            if (i == 0) begin : g_first
                always_ff @(posedge w_src or posedge w_pre_clr) begin
                    if (w_pre_clr) r_q <= 1'b0;
                    else           r_q <= ~r_q;
                end
            end else begin : g_next
                // Each stage toggles on the falling edge of the previous one.
                always_ff @(negedge g_pre_stage[i-1].r_q or posedge w_pre_clr) begin
                    if (w_pre_clr) r_q <= 1'b0;
                    else           r_q <= ~r_q;
                end
            end
        end
        assign w_pre_out = g_pre_stage[PRESCALE_BITS-1].r_q;
    end

    // Rising edge of the synchronised prescaler output.
    assign w_inc      = r_sync2 & ~r_sync3;
    // A zero window length counts for one cycle.
    assign w_win_load = (bus.window_cycles == '0) ? c_win_one : bus.window_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_idle;
            r_settle   <= '0;
            r_osc_sel  <= '0;
            r_src_ext  <= 1'b0;
            r_win      <= '0;
            r_edge     <= '0;
            r_sat      <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
        end else begin
            r_sync1 <= w_pre_out;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_done  <= 1'b0;

            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_state   <= c_settle;
                        r_settle  <= '0;
                        r_osc_sel <= bus.osc_sel;
                        r_src_ext <= bus.src_ext;
                    end
                end
                c_settle: begin
                    // Lets the ring start up and flushes stale synchroniser data.
                    r_settle <= r_settle + 2'd1;
                    if (r_settle == c_settle_last) begin
                        r_state <= c_measure;
                        r_win   <= w_win_load;
                        r_edge  <= '0;
                        r_sat   <= 1'b0;
                    end
                end
                c_measure: begin
                    r_win <= r_win - c_win_one;
                    if (w_inc) begin
                        if (r_edge == c_cnt_max) r_sat  <= 1'b1;
                        else                     r_edge <= r_edge + 1'b1;
                    end
                    if (r_win == c_win_one) r_state <= c_done;
                end
                c_done: begin
                    r_result   <= r_edge;
                    r_overflow <= r_sat;
                    r_done     <= 1'b1;
                    if (bus.continuous) begin
                        // Back-to-back window: the ring keeps running, no settle.
                        r_state <= c_measure;
                        r_win   <= w_win_load;
                        r_edge  <= '0;
                        r_sat   <= 1'b0;
                    end else begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // busy stays high through the done pulse and drops the cycle after.
    assign bus.busy     = (r_state != c_idle) | r_done;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire

// File: doc/ringosc_freq_meter.md
Name: ringosc_freq_meter

Overview:
- Multi-channel ring-oscillator frequency meter.
- NUM_OSC free-running ring oscillators of increasing length, plus an external test source.
- The selected source is divided by a ripple prescaler, synchronised into clk, and its rising edges are counted over a programmable window of clk cycles.
- Supports single-shot and continuous measurement, a saturating result and an overflow flag; intended as the on-chip process/voltage monitor behind the user-project I/O.

Parameters:
- NUM_OSC, 4, number of ring oscillators; oscillator k has OSC_LEN + 2*k inverters (always odd).
- OSC_LEN, 13, inverter count of oscillator 0; must be odd and >= 3.
- PRESCALE_BITS, 8, ripple divider stages; divide ratio 2^PRESCALE_BITS; 0 = bypass.
- CNT_WIDTH, 32, edge-counter and result width.
- WINDOW_BITS, 24, width of the window length.

Ports:
- clk  in  1  system clock; all registers outside oscillator/prescaler are on rising clk.
- rst  in  1  synchronous, active-high reset.
- osc_sel  in  clog2(NUM_OSC)  oscillator select; sampled on accepted start.
- src_ext  in  1  1 = count ext_osc instead of a ring; sampled on accepted start.
- ext_osc  in  1  external test source.
- start  in  1  begin a measurement (level-sampled, one cycle sufficient).
- continuous  in  1  1 = re-arm automatically after each window; sampled every window end.
- window_cycles  in  WINDOW_BITS  window length in clk cycles; 0 treated as 1; sampled at each window start.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse when result updates.
- result  out  CNT_WIDTH  edge count of last completed window.
- overflow  out  1  last completed window saturated.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, overflow=0; edge counter, window counter and sync flops 0; all oscillators stopped; prescaler held in reset.
- Oscillators: each ring's first stage is gated (forced 0) unless the ring is selected, src_ext=0 and the state is not IDLE. Unselected rings never toggle.
- Source mux: src_sel_q and osc_sel_q are latched at the accepted start; mid-measurement input changes are ignored.
- Prescaler: ripple toggle chain on the muxed source, held reset while IDLE. Output is bit PRESCALE_BITS-1, or the raw source when PRESCALE_BITS=0.
- Sync: prescaled signal passes through a 2-flop synchroniser plus one edge-detect flop. A rising edge produces an inc pulse one clk later.
- Legal input range: prescaled frequency < clk/2; faster inputs undercount with no error flag.
- States:
  - IDLE: start=1 -> SETTLE. Latch selects, busy=1.
  - SETTLE: fixed 4 clk cycles (oscillator start-up and synchroniser flush; inc ignored) -> MEASURE. Load window counter with max(window_cycles,1), clear edge counter and sat flag.
  - MEASURE: each cycle decrement the window counter; inc increments the edge counter.
    - At CNT_WIDTH all-ones, further incs hold the value and set sat.
    - An inc in the same cycle the window counter reaches 1 is counted.
    - When the window counter = 1 -> DONE.
  - DONE (1 cycle): result <= edge counter, overflow <= sat, done=1. Then:
    - continuous=1 -> MEASURE directly: reload window, clear counters, no SETTLE, oscillator keeps running.
    - otherwise -> IDLE, busy=0.
- Window length: exactly N clk cycles of counting (N = loaded value). Measurement latency from start to done = 4 + N + 1 cycles after start is sampled.
- start while busy: ignored. Clearing continuous mid-window: the current window completes, then IDLE.
- result/overflow: hold between done pulses; never change except in DONE or on rst.
- rst mid-measurement: immediate return to reset state next clk; result is cleared; no done pulse.

Test Plan:
- Reset values: assert rst 3 cycles during a running continuous measurement -> busy=0, done=0, result=0, overflow=0 next cycle; no done afterwards.
- Single-shot count: PRESCALE_BITS=2, src_ext=1, ext_osc toggling every clk (period 2), window_cycles=800 -> done exactly 805 cycles after start sampled, result in {99,100,101}, overflow=0, busy low the cycle after done.
- Zero window: window_cycles=0, ext_osc static 0 -> done 6 cycles after start, result=0.
- Continuous mode: window_cycles=80, same ext source, continuous=1 -> done every 81 cycles with result in {9,10,11}. Drop continuous mid-window -> exactly one more done, then busy=0.
- Saturation: CNT_WIDTH=4, PRESCALE_BITS=0, ext_osc period 4 clk, window_cycles=200 -> result=15, overflow=1. Next run with window_cycles=20 -> result in {4,5,6}, overflow=0.
- Ring oscillators (gate-level or delay-annotated sim): sweep osc_sel 0..NUM_OSC-1, src_ext=0, window 1000 -> result strictly decreasing with osc_sel. Unselected rings show no toggles. start while busy changes nothing.
